// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   fwd_sel_t  : EX ALU operand select (register file / writeback / memory)
//   mc_state_t : multi-cycle sequencer state
//   fwd_select : forwarding priority (M over W, x0 never forwarded)
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

    function automatic fwd_sel_t fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_MEM;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_controller_mc_sequencer.sv
// mc_sequencer
// Holds the pipeline while a multi-cycle EX operation runs for MC_LATENCY
// cycles. mc_cnt is a down-counter loaded with MC_LATENCY-2 on start; the
// cycle where it reads zero in BUSY is the completion cycle.
//
// state | meaning
// IDLE  | no multi-cycle op in flight; MultiCycleE starts one (McStartE)
// BUSY  | op in flight; hold while mc_cnt!=0, McDoneE when mc_cnt==0
//
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   MultiCycleE   : EX instruction needs the multi-cycle unit
//   mcHold        : hold F/D/E, bubble M
//   McStartE      : one-cycle pulse on the start cycle
//   McDoneE       : one-cycle pulse on the completion cycle
module mc_sequencer
    import hazard_pkg::*;
#(
    parameter int MC_LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic MultiCycleE,
    output logic mcHold,
    output logic McStartE,
    output logic McDoneE
);

    // Counter only needs to hold 0..MC_LATENCY-2; keep at least one bit.
    localparam int CNT_W = (MC_LATENCY > 2) ? $clog2(MC_LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 2);

    mc_state_t        state;
    logic [CNT_W-1:0] mc_cnt;
    logic             idle_start;
    logic             busy_run;
    logic             busy_last;

    assign idle_start = (state == IDLE) && MultiCycleE;
    assign busy_run   = (state == BUSY) && (mc_cnt != '0);
    assign busy_last  = (state == BUSY) && (mc_cnt == '0);

    // Outputs are suppressed while reset is high so an aborted op never
    // reports completion.
    assign mcHold   = !reset && (idle_start || busy_run);
    assign McStartE = !reset && idle_start;
    assign McDoneE  = !reset && busy_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mc_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MultiCycleE) begin
                        state  <= BUSY;
                        mc_cnt <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (mc_cnt != '0)
                        mc_cnt <= mc_cnt - 1'b1;
                    else
                        state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    mc_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller
// Hazard unit for the 5-stage RISC-V pipeline: EX operand forwarding,
// load-use stall, branch/jump flush, multi-cycle EX hold and a saturating
// stall-cycle counter.
//
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   Rs1D/Rs2D                    : Decode source registers
//   Rs1E/Rs2E/RdE                : Execute source/destination registers
//   RdM/RegWriteM, RdW/RegWriteW : later-stage destinations and write enables
//   ResultSrcE                   : EX result source (01 = load)
//   PCSrcE                       : taken branch/jump resolved in EX
//   MultiCycleE                  : EX instruction uses the multi-cycle unit
//   ForwardAE/ForwardBE          : ALU operand selects (00 RF, 01 W, 10 M)
//   StallF/StallD/StallE         : pipeline register holds
//   FlushD/FlushE/FlushM         : pipeline register clears
//   McStartE/McDoneE             : multi-cycle start / completion pulses
//   StallCount                   : saturating count of StallD cycles
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MC_LATENCY  = 4,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             Rs1D,
    input  logic [4:0]             Rs2D,
    input  logic [4:0]             Rs1E,
    input  logic [4:0]             Rs2E,
    input  logic [4:0]             RdE,
    input  logic [4:0]             RdM,
    input  logic [4:0]             RdW,
    input  logic [1:0]             ResultSrcE,
    input  logic                   RegWriteM,
    input  logic                   RegWriteW,
    input  logic                   PCSrcE,
    input  logic                   MultiCycleE,
    output logic [1:0]             ForwardAE,
    output logic [1:0]             ForwardBE,
    output logic                   StallF,
    output logic                   StallD,
    output logic                   StallE,
    output logic                   FlushD,
    output logic                   FlushE,
    output logic                   FlushM,
    output logic                   McStartE,
    output logic                   McDoneE,
    output logic [STALL_CNT_W-1:0] StallCount
);

    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;
    logic     lw_stall;
    logic     mc_hold;

    mc_sequencer #(
        .MC_LATENCY (MC_LATENCY)
    ) u_mc_sequencer (
        .clk         (clk),
        .reset       (reset),
        .MultiCycleE (MultiCycleE),
        .mcHold      (mc_hold),
        .McStartE    (McStartE),
        .McDoneE     (McDoneE)
    );

    assign fwd_a = fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign fwd_b = fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

    assign ForwardAE = reset ? FWD_RF : fwd_a;
    assign ForwardBE = reset ? FWD_RF : fwd_b;

    assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                      ((Rs1D == RdE) || (Rs2D == RdE));

    // mc_hold is already forced low by the sequencer during reset.
    assign StallF = !reset && (lw_stall || mc_hold);
    assign StallD = StallF;
    assign StallE = mc_hold;

    // A held EX instruction must not be bubbled, so mc_hold masks FlushE.
    assign FlushD = reset || PCSrcE;
    assign FlushE = reset || ((lw_stall || PCSrcE) && !mc_hold);
    assign FlushM = reset || mc_hold;

    always_ff @(posedge clk) begin
        if (reset)
            StallCount <= '0;
        else if (StallD && (StallCount != '1))
            StallCount <= StallCount + 1'b1;
    end

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

    localparam int MC_LAT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       RegWriteM, RegWriteW, PCSrcE, MultiCycleE;

    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, McStartE, McDoneE;
    logic [31:0] StallCount;

    logic [1:0]  s_ForwardAE, s_ForwardBE;
    logic        s_StallF, s_StallD, s_StallE, s_FlushD, s_FlushE, s_FlushM;
    logic        s_McStartE, s_McDoneE;
    logic [2:0]  s_StallCount;

    always #5 clk = ~clk;

    hazard_controller #(.MC_LATENCY(MC_LAT), .STALL_CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
        .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .McStartE(McStartE), .McDoneE(McDoneE), .StallCount(StallCount)
    );

    hazard_controller #(.MC_LATENCY(MC_LAT), .STALL_CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE),
        .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE), .StallF(s_StallF), .StallD(s_StallD),
        .StallE(s_StallE), .FlushD(s_FlushD), .FlushE(s_FlushE), .FlushM(s_FlushM),
        .McStartE(s_McStartE), .McDoneE(s_McDoneE), .StallCount(s_StallCount)
    );

    // {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
    //  McStartE, McDoneE, StallCount}
    typedef logic [43:0] obs_t;
    obs_t obs;
    assign obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
                  McStartE, McDoneE, StallCount};

    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    bit          m_busy  = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_count = '0;
    logic [2:0]  m_sat   = '0;

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic obs_t model_out();
        logic lw, hold, start, done;
        if (reset) return {4'b0000, 6'b000111, 2'b00, m_count};
        lw    = (ResultSrcE == 2'b01) && (RdE != 5'd0) && (Rs1D == RdE || Rs2D == RdE);
        hold  = (!m_busy && MultiCycleE) || (m_busy && m_cnt != 0);
        start = !m_busy && MultiCycleE;
        done  = m_busy && m_cnt == 0;
        return {m_fwd(Rs1E), m_fwd(Rs2E), lw | hold, lw | hold, hold,
                PCSrcE, (lw | PCSrcE) & ~hold, hold, start, done, m_count};
    endfunction

    task automatic model_step();
        obs_t e;
        e = model_out();
        if (reset) begin
            m_busy = 1'b0; m_cnt = 0; m_count = '0; m_sat = '0;
        end else begin
            if (e[38] && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            if (e[38] && m_sat != 3'd7) m_sat = m_sat + 3'd1;
            if (!m_busy) begin
                if (MultiCycleE) begin m_busy = 1'b1; m_cnt = MC_LAT - 2; end
            end else if (m_cnt != 0) m_cnt = m_cnt - 1;
            else m_busy = 1'b0;
        end
    endtask

    task automatic push_expect();
        sb.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 2'b00; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MultiCycleE = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t exp;
        reset = 1'b1;
        Rs1E = 5; RdM = 5; RegWriteM = 1; MultiCycleE = 1; ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
        for (int i = 0; i < 3; i++) begin
            push_expect();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset[%0d]: got %h expected %h", i, obs, exp);
            end
            checks++;
            if ({ForwardAE, StallF, StallD, StallE, FlushD, FlushE, FlushM, McStartE, McDoneE} !== 10'b00_000111_00) begin
                errors++;
                $display("FAIL reset_forced[%0d]: got %b expected 0000011100",
                         i, {ForwardAE, StallF, StallD, StallE, FlushD, FlushE, FlushM, McStartE, McDoneE});
            end
            advance();
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_forwarding();
        obs_t exp;
        logic [1:0] ea, eb;
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            case (i)
                0: begin RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0; ea = 2'b10; eb = 2'b00; end
                1: begin RdM = 5; RegWriteM = 0; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0; ea = 2'b01; eb = 2'b00; end
                2: begin RdM = 0; RegWriteM = 1; RdW = 0; RegWriteW = 1; Rs1E = 0; Rs2E = 0; ea = 2'b00; eb = 2'b00; end
                default: begin RdM = 3; RegWriteM = 1; RdW = 9; RegWriteW = 1; Rs1E = 9; Rs2E = 3; ea = 2'b01; eb = 2'b10; end
            endcase
            push_expect();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL fwd[%0d]: got %h expected %h", i, obs, exp);
            end
            checks++;
            if ({ForwardAE, ForwardBE} !== {ea, eb}) begin
                errors++;
                $display("FAIL fwd_sel[%0d]: got A=%b B=%b expected A=%b B=%b", i, ForwardAE, ForwardBE, ea, eb);
            end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        obs_t exp;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            clear_inputs();
            if (i == 0) begin ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; end
            push_expect();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL load_use[%0d]: got %h expected %h", i, obs, exp);
            end
            checks++;
            if (i == 0 && {StallF, StallD, StallE, FlushE} !== 4'b1101) begin
                errors++;
                $display("FAIL load_use_ctrl: got %b expected 1101", {StallF, StallD, StallE, FlushE});
            end else if (i == 1 && ({StallF, StallD, StallE} !== 3'b000 || StallCount !== 32'd1)) begin
                errors++;
                $display("FAIL load_use_release: got stalls %b count %0d expected 000 and 1",
                         {StallF, StallD, StallE}, StallCount);
            end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        obs_t exp;
        for (int i = 0; i < 2; i++) begin
            clear_inputs();
            PCSrcE = 1;
            if (i == 1) begin ResultSrcE = 2'b01; RdE = 4; Rs1D = 4; end
            push_expect();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL branch[%0d]: got %h expected %h", i, obs, exp);
            end
            checks++;
            if ({FlushD, FlushE, StallF, StallD, StallE} !== ((i == 0) ? 5'b11000 : 5'b11110)) begin
                errors++;
                $display("FAIL branch_ctrl[%0d]: got %b expected %b", i,
                         {FlushD, FlushE, StallF, StallD, StallE}, (i == 0) ? 5'b11000 : 5'b11110);
            end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back_multicycle();
        obs_t exp;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            clear_inputs();
            MultiCycleE = (i < 8);
            push_expect();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mc[%0d]: got %h expected %h", i, obs, exp);
            end
            if (i < 8) begin
                checks++;
                if ({McStartE, McDoneE, StallD, StallE, FlushM} !==
                    {(i % 4 == 0), (i % 4 == 3), {3{(i % 4 != 3)}}}) begin
                    errors++;
                    $display("FAIL mc_seq[%0d]: got start=%b done=%b stallD=%b stallE=%b flushM=%b",
                             i, McStartE, McDoneE, StallD, StallE, FlushM);
                end
            end
            if (i == 3 || i == 8) begin
                checks++;
                if (StallCount !== ((i == 3) ? 32'd3 : 32'd6)) begin
                    errors++;
                    $display("FAIL mc_count[%0d]: got %0d expected %0d", i, StallCount, (i == 3) ? 3 : 6);
                end
            end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_busy();
        obs_t exp;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            MultiCycleE = (i < 2);
            reset = (i == 1);
            push_expect();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_busy[%0d]: got %h expected %h", i, obs, exp);
            end
            if (i == 1) begin
                checks++;
                if ({FlushD, FlushE, FlushM, StallF, StallD, StallE, McDoneE} !== 7'b1110000) begin
                    errors++;
                    $display("FAIL reset_busy_ctrl: got %b expected 1110000",
                             {FlushD, FlushE, FlushM, StallF, StallD, StallE, McDoneE});
                end
            end else if (i >= 2) begin
                checks++;
                if (McDoneE !== 1'b0 || StallD !== 1'b0 || StallCount !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_busy_after[%0d]: got done=%b stallD=%b count=%0d expected 0 0 0",
                             i, McDoneE, StallD, StallCount);
                end
            end
            advance();
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_saturation();
        obs_t exp;
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            clear_inputs();
            if (i < 10) begin ResultSrcE = 2'b01; RdE = 12; Rs1D = 12; end
            push_expect();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp || s_StallCount !== m_sat) begin
                errors++;
                $display("FAIL sat[%0d]: got %h / %0d expected %h / %0d", i, obs, s_StallCount, exp, m_sat);
            end
            if (i >= 7) begin
                checks++;
                if (s_StallCount !== 3'd7) begin
                    errors++;
                    $display("FAIL sat_hold[%0d]: got %0d expected 7", i, s_StallCount);
                end
            end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_random();
        obs_t exp;
        for (int i = 0; i < 60; i++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            MultiCycleE = ($urandom_range(0, 3) == 0);
            PCSrcE = !MultiCycleE && ($urandom_range(0, 3) == 0);
            push_expect();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp || s_StallCount !== m_sat) begin
                errors++;
                $display("FAIL random[%0d]: got %h / %0d expected %h / %0d", i, obs, s_StallCount, exp, m_sat);
            end
            advance();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_back_to_back_multicycle();
        test_reset_mid_busy();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
